// File: rtl/jk_flip_flop.sv
// jk_flip_flop: WIDTH independent JK flip-flops with clock enable and synchronous reset.
// Define JK_FF_TOGGLE_CNT_EN to add a saturating 16-bit TOGGLE_CNT of enabled edges that change Q1.
module jk_flip_flop #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2
`ifdef JK_FF_TOGGLE_CNT_EN
  ,
  output logic [15:0]      TOGGLE_CNT
`endif
);
  logic [WIDTH-1:0] nxt;
  assign nxt = (J & ~Q1) | (~K & Q1);
  assign Q2 = ~Q1;
  always_ff @(posedge CLK)
    if (RST) Q1 <= RESET_VAL;
    else if (CE) Q1 <= nxt;
`ifdef JK_FF_TOGGLE_CNT_EN
  always_ff @(posedge CLK)
    if (RST) TOGGLE_CNT <= '0;
    else if (CE && nxt != Q1 && TOGGLE_CNT != 16'hFFFF) TOGGLE_CNT <= TOGGLE_CNT + 16'd1;
`endif
endmodule

// File: tb/tb_jk_flip_flop.sv
// tb_jk_flip_flop: directed JK vectors on a 1-bit and a 4-bit instance, checked through a scoreboard queue.
module tb_jk_flip_flop;
  typedef struct {
    string       name;
    bit          wide;
    logic [3:0]  q;
    logic [15:0] cnt;
  } exp_t;

  logic        CLK = 0;
  logic        rst1, ce1, j1, k1;
  logic [0:0]  q1_a, q2_a;
  logic        rst4, ce4;
  logic [3:0]  j4, k4, q1_b, q2_b;
  logic [15:0] cnt_a, cnt_b;
  exp_t        sb[$];
  int          checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  jk_flip_flop dut1 (
    .CLK(CLK), .RST(rst1), .CE(ce1), .J(j1), .K(k1), .Q1(q1_a), .Q2(q2_a)
`ifdef JK_FF_TOGGLE_CNT_EN
    , .TOGGLE_CNT(cnt_a)
`endif
  );

  jk_flip_flop #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (
    .CLK(CLK), .RST(rst4), .CE(ce4), .J(j4), .K(k4), .Q1(q1_b), .Q2(q2_b)
`ifdef JK_FF_TOGGLE_CNT_EN
    , .TOGGLE_CNT(cnt_b)
`endif
  );

`ifndef JK_FF_TOGGLE_CNT_EN
  assign cnt_a = '0;
  assign cnt_b = '0;
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge CLK)
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (!e.wide) begin
        check({e.name, " q1"}, {15'd0, q1_a}, {15'd0, e.q[0]});
        check({e.name, " q2"}, {15'd0, q2_a}, {15'd0, ~e.q[0]});
      end else begin
        check({e.name, " q1"}, {12'd0, q1_b}, {12'd0, e.q});
        check({e.name, " q2"}, {12'd0, q2_b}, {12'd0, ~e.q});
`ifdef JK_FF_TOGGLE_CNT_EN
        check({e.name, " cnt"}, cnt_b, e.cnt);
`endif
      end
    end

  task automatic step1(input string name, input logic r, input logic c, input logic j, input logic k,
                       input logic q);
    @(negedge CLK);
    rst1 = r; ce1 = c; j1 = j; k1 = k;
    @(posedge CLK);
    sb.push_back('{name, 1'b0, {3'd0, q}, 16'd0});
  endtask

  task automatic step4(input string name, input logic r, input logic c, input logic [3:0] j,
                       input logic [3:0] k, input logic [3:0] q, input logic [15:0] cnt);
    @(negedge CLK);
    rst4 = r; ce4 = c; j4 = j; k4 = k;
    @(posedge CLK);
    sb.push_back('{name, 1'b1, q, cnt});
  endtask

  initial begin
    rst1 = 0; ce1 = 1; j1 = 0; k1 = 0;
    rst4 = 0; ce4 = 0; j4 = 0; k4 = 0;
    step1("reset",      1, 1, 0, 0, 0);
    step1("set",        0, 1, 1, 0, 1);
    step1("hold_a",     0, 1, 0, 0, 1);
    step1("hold_b",     0, 1, 0, 0, 1);
    step1("clear",      0, 1, 0, 1, 0);
    step1("toggle_1",   0, 1, 1, 1, 1);
    step1("toggle_2",   0, 1, 1, 1, 0);
    step1("toggle_3",   0, 1, 1, 1, 1);
    step1("toggle_4",   0, 1, 1, 1, 0);
    step1("set_again",  0, 1, 1, 0, 1);
    step1("rst_prio",   1, 0, 1, 1, 0);
    step1("after_rst",  0, 1, 1, 0, 1);
    @(negedge CLK);
    j1 = 0; k1 = 0; ce1 = 1;
    #1 rst1 = 1;
    #2 rst1 = 0;
    #1 check("rst_between_q1", {15'd0, q1_a}, 16'd1);
    @(posedge CLK);
    sb.push_back('{"rst_between_edge", 1'b0, 4'd1, 16'd0});
    step1("ce_off_hold", 0, 0, 0, 1, 1);
    step1("tog_pre_rst", 0, 1, 1, 1, 0);
    step1("tog_pre_rst2",0, 1, 1, 1, 1);
    step1("rst_in_tog",  1, 1, 1, 1, 0);
    step1("tog_post_rst",0, 1, 1, 1, 1);

    step4("w_reset",    1, 0, 4'h0, 4'h0, 4'b1010, 16'd0);
    step4("w_ce_off",   0, 0, 4'hF, 4'hF, 4'b1010, 16'd0);
    step4("w_toggle",   0, 1, 4'hF, 4'hF, 4'b0101, 16'd1);
    step4("w_mixed",    0, 1, 4'b0011, 4'b0101, 4'b0010, 16'd2);
    step4("w_hold",     0, 1, 4'h0, 4'h0, 4'b0010, 16'd2);
    step4("w_set_all",  0, 1, 4'hF, 4'h0, 4'b1111, 16'd3);
    step4("w_reset2",   1, 1, 4'hF, 4'hF, 4'b1010, 16'd0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jk_flip_flop.md
JK_FLIP_FLOP -- requirements
Module: jk_flip_flop

Interface
REQ-001 Parameter WIDTH, default 1: number of independent JK bits; legal range 1..32.
REQ-002 Parameter RESET_VAL, default 0 (WIDTH bits): value loaded into Q1 on reset.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  clock; all state changes on rising edge only.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 CE  input  1  clock enable; 1 = evaluate J/K, 0 = hold all bits.
REQ-007 J  input  WIDTH  per-bit J (set) input.
REQ-008 K  input  WIDTH  per-bit K (reset) input.
REQ-009 Q1  output  WIDTH  registered true output.
REQ-010 Q2  output  WIDTH  complement output; Q2 SHALL equal ~Q1 at all times, with no extra register stage or delay.

Function
REQ-011 Each bit i SHALL update at the CLK rising edge when CE=1 and RST=0, per J[i]/K[i]:
- J=0,K=0: hold.
- J=0,K=1: Q1[i]=0.
- J=1,K=0: Q1[i]=1.
- J=1,K=1: Q1[i]=~Q1[i] (toggle).
REQ-012 Bits SHALL be fully independent; no cross-bit interaction.
REQ-013 Latency: a J/K change SHALL affect Q1 exactly at the next rising edge, never combinationally.
REQ-014 J/K changes between edges SHALL have no effect; only values sampled at the edge count.
REQ-015 CE=0 SHALL hold Q1 regardless of J/K.
REQ-016 J=K=1 held over N enabled edges SHALL toggle the bit N times (alternating every cycle).
REQ-017 Q1 SHALL be a plain register output with no glitches; Q2 is derived only from Q1.

Reset
REQ-018 RST=1 at a rising edge SHALL load Q1=RESET_VAL and therefore Q2=~RESET_VAL.
REQ-019 Reset SHALL take priority over CE, J and K.
REQ-020 Reset asserted mid-operation, including during continuous toggling, SHALL take effect at that same edge.
REQ-021 Asserting RST between edges SHALL NOT change outputs; this is a synchronous reset only.
REQ-022 Before the first reset edge, output values SHALL be treated as unspecified.
REQ-023 On the first enabled edge after RST deasserts, normal J/K evaluation SHALL apply.

Configuration
REQ-024 Macro JK_FF_TOGGLE_CNT_EN SHALL control one optional feature.
- Defined: adds output TOGGLE_CNT (16 bits).
- TOGGLE_CNT increments by 1 on each enabled edge where any Q1 bit changes value.
- TOGGLE_CNT saturates at 16'hFFFF and clears to 0 on reset.
REQ-025 Macro undefined: the TOGGLE_CNT port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=1, RESET_VAL=0, CE=1 unless stated)
REQ-026 Set: RST=1 for one edge, then J=1,K=0 -> Q1=1, Q2=0 after the next edge.
REQ-027 Hold then reset:
- From Q1=1, J=0,K=0 for 2 edges -> Q1 stays 1.
- Then J=0,K=1 -> Q1=0 after the next edge.
REQ-028 Toggle: from Q1=0, J=1,K=1 for 4 edges -> Q1 sequence 1,0,1,0, with Q2 always the complement.
REQ-029 Reset priority: from Q1=1, J=1,K=1, CE=0, RST=1 at an edge -> Q1=0, Q2=1.
- The same RST pulse placed between edges produces no change.
REQ-030 Enable/width: WIDTH=4, RESET_VAL=4'b1010, CE=0 with J=4'hF,K=4'hF -> Q1 holds 4'b1010.
- Then CE=1 for one edge -> Q1=4'b0101.
- With JK_FF_TOGGLE_CNT_EN defined: TOGGLE_CNT=1 after that edge, and 0 after a reset.
